// File: rtl/vga_dither_out.sv
// Registered VGA output stage: colour-depth reduction with optional 4x4 ordered dithering.
// Define VGA_DITHER_TEMPORAL_EN to rotate the Bayer pattern every frame.
module vga_dither_out #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 4,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             CLK_25MHZ,
  input  logic             RESET,
  input  logic             DITHER_EN,
  input  logic             VSYNC_IN,
  input  logic             HSYNC_IN,
  input  logic [IN_W-1:0]  RED_IN,
  input  logic [IN_W-1:0]  GREEN_IN,
  input  logic [IN_W-1:0]  BLUE_IN,
  output logic             VGA_VSYNC,
  output logic             VGA_HSYNC,
  output logic [OUT_W-1:0] VGA_RED,
  output logic [OUT_W-1:0] VGA_GREEN,
  output logic [OUT_W-1:0] VGA_BLUE
);

  localparam int unsigned D    = IN_W - OUT_W;
  localparam logic        IDLE = ~SYNC_POL;

  logic       hs_prev, vs_prev;
  logic       hs_edge_c, vs_edge_c;
  logic [1:0] px, py;
  logic       mode;
  logic [1:0] row_c, col_c;
  logic [3:0] bay_c;

  assign hs_edge_c = (HSYNC_IN == SYNC_POL) && (hs_prev != SYNC_POL);
  assign vs_edge_c = (VSYNC_IN == SYNC_POL) && (vs_prev != SYNC_POL);

`ifdef VGA_DITHER_TEMPORAL_EN
  logic [1:0] fr;
  assign row_c = py ^ fr;
  assign col_c = px ^ {fr[0], fr[1]};
`else
  assign row_c = py;
  assign col_c = px;
`endif

  // Pixel position tracking and frame-boundary mode latch
  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      hs_prev <= IDLE;
      vs_prev <= IDLE;
      px      <= 2'd0;
      py      <= 2'd0;
      mode    <= 1'b0;
`ifdef VGA_DITHER_TEMPORAL_EN
      fr      <= 2'd0;
`endif
    end else begin
      hs_prev <= HSYNC_IN;
      vs_prev <= VSYNC_IN;
      px      <= hs_edge_c ? 2'd0 : px + 2'd1;
      if (vs_edge_c)      py <= 2'd0;
      else if (hs_edge_c) py <= py + 2'd1;
      if (vs_edge_c) mode <= DITHER_EN;
`ifdef VGA_DITHER_TEMPORAL_EN
      if (vs_edge_c) fr <= fr + 2'd1;
`endif
    end
  end

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    case ({row, col})
      4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
      4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
      4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
      4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
    endcase
    return v;
  endfunction

  assign bay_c = bayer(row_c, col_c);

  logic [IN_W-1:0]  in_c  [3];
  logic [OUT_W-1:0] nxt_c [3];
  logic [OUT_W-1:0] s1    [3];
  logic             hs_s1, vs_s1;

  assign in_c[0] = RED_IN;
  assign in_c[1] = GREEN_IN;
  assign in_c[2] = BLUE_IN;

  // Stage-1 value per channel; only the bits that reach the pins are stored
  generate
    if (D == 0) begin : g_pass
      for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        assign nxt_c[ch] = in_c[ch];
      end
    end else begin : g_dith
      logic [IN_W-1:0] t_c;
      if (D >= 4) begin : g_shl
        assign t_c = IN_W'(bay_c) << (D - 4);
      end else begin : g_shr
        assign t_c = IN_W'(bay_c >> (4 - D));
      end
      for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [IN_W:0] sum_c;
        logic          unused_c;
        assign sum_c     = {1'b0, in_c[ch]} + {1'b0, t_c};
        assign unused_c  = ^sum_c[D-1:0];
        assign nxt_c[ch] = !mode      ? in_c[ch][IN_W-1:D] :
                           sum_c[IN_W] ? {OUT_W{1'b1}} : sum_c[IN_W-1:D];
      end
    end
  endgenerate

  // Two-stage pipeline; syncs ride alongside colour unmodified
  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      for (int ch = 0; ch < 3; ch++) s1[ch] <= '0;
      hs_s1     <= IDLE;
      vs_s1     <= IDLE;
      VGA_RED   <= '0;
      VGA_GREEN <= '0;
      VGA_BLUE  <= '0;
      VGA_HSYNC <= IDLE;
      VGA_VSYNC <= IDLE;
    end else begin
      for (int ch = 0; ch < 3; ch++) s1[ch] <= nxt_c[ch];
      hs_s1     <= HSYNC_IN;
      vs_s1     <= VSYNC_IN;
      VGA_RED   <= s1[0];
      VGA_GREEN <= s1[1];
      VGA_BLUE  <= s1[2];
      VGA_HSYNC <= hs_s1;
      VGA_VSYNC <= vs_s1;
    end
  end

endmodule
